bus_dma: RTL and testbench

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma_pkg.sv | 24 ++
 rtl/bus_dma_regs.sv | 77 +++++++
 rtl/bus_dma.sv | 113 +++++++++++
 tb/tb_bus_dma.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// rtl/bus_dma_pkg.sv - shared encodings for the bus_dma block
package bus_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_SRC    = 8'h10;
  localparam logic [7:0] ADDR_DST    = 8'h11;
  localparam logic [7:0] ADDR_LEN    = 8'h12;
  localparam logic [7:0] ADDR_MODE   = 8'h13;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_ABORTED = 2;
  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;

endpackage

// File: rtl/bus_dma_regs.sv
// rtl/bus_dma_regs.sv - register file, command decode and read port timing
module bus_dma_regs
  import bus_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [7:0]  address_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  status_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        start_o,
  output logic        abort_o,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic [15:0] len_o,
  output logic        mode_o
);

  logic [31:0] src_q, dst_q, read_data_q, read_data_d;
  logic [15:0] len_q;
  logic        mode_q, ready_q;
  logic        ctrl_wr, busy;

  assign busy    = status_i[STATUS_BUSY];
  assign ctrl_wr = cs_i && we_i && (address_i == ADDR_CTRL);
  // Abort wins over a start carried in the same write.
  assign abort_o = ctrl_wr && write_data_i[CTRL_ABORT];
  assign start_o = ctrl_wr && write_data_i[CTRL_START] && !write_data_i[CTRL_ABORT];

  always_comb begin
    read_data_d = 32'h0;
    if (!we_i) begin
      case (address_i)
        ADDR_STATUS: read_data_d = {29'h0, status_i};
        ADDR_SRC:    read_data_d = src_q;
        ADDR_DST:    read_data_d = dst_q;
        ADDR_LEN:    read_data_d = {16'h0, len_q};
        ADDR_MODE:   read_data_d = {31'h0, mode_q};
        default:     read_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q       <= 32'h0;
      dst_q       <= 32'h0;
      len_q       <= 16'h0;
      mode_q      <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= 32'h0;
    end else begin
      ready_q <= cs_i;
      if (cs_i) read_data_q <= read_data_d;
      if (cs_i && we_i && !busy) begin
        case (address_i)
          ADDR_SRC:  src_q  <= write_data_i;
          ADDR_DST:  dst_q  <= write_data_i;
          ADDR_LEN:  len_q  <= write_data_i[15:0];
          ADDR_MODE: mode_q <= write_data_i[0];
          default:   ;
        endcase
      end
    end
  end

  assign read_data_o = read_data_q;
  assign ready_o     = ready_q;
  assign src_o       = src_q;
  assign dst_o       = dst_q;
  assign len_o       = len_q;
  assign mode_o      = mode_q;

endmodule

// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - copy/fill DMA engine on a picorv32-style native bus
module bus_dma
  import bus_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        mem_instr,
  output logic        done
);

  state_e      state_q;
  logic [31:0] src_q, dst_q, buf_q, mem_addr_q, mem_wdata_q;
  logic [15:0] rem_q;
  logic [3:0]  mem_wstrb_q;
  logic        fill_q, last_rd_q, abort_pend_q, done_q, st_done_q, st_abort_q, mem_valid_q;
  logic        start, abort, mode;
  logic [31:0] src, dst, src_al, dst_al;
  logic [15:0] len;
  logic        busy;

  assign busy   = (state_q != ST_IDLE);
  assign src_al = {src[31:2], 2'b00};
  assign dst_al = {dst[31:2], 2'b00};

  bus_dma_regs u_regs (
    .clk          (clk),
    .reset        (reset),
    .cs_i         (cs),
    .we_i         (we),
    .address_i    (address),
    .write_data_i (write_data),
    .status_i     ({st_abort_q, st_done_q, busy}),
    .read_data_o  (read_data),
    .ready_o      (ready),
    .start_o      (start),
    .abort_o      (abort),
    .src_o        (src),
    .dst_o        (dst),
    .len_o        (len),
    .mode_o       (mode)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q <= 32'h0; dst_q <= 32'h0; buf_q <= 32'h0; rem_q <= 16'h0;
      fill_q <= 1'b0; last_rd_q <= 1'b0; abort_pend_q <= 1'b0;
      done_q <= 1'b0; st_done_q <= 1'b0; st_abort_q <= 1'b0;
      mem_valid_q <= 1'b0; mem_addr_q <= 32'h0; mem_wdata_q <= 32'h0; mem_wstrb_q <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          st_done_q <= 1'b0; st_abort_q <= 1'b0; abort_pend_q <= 1'b0;
          if (len == 16'h0) begin
            done_q <= 1'b1; st_done_q <= 1'b1;
          end else begin
            src_q <= mode ? src : src_al;
            dst_q <= dst_al; rem_q <= len; fill_q <= mode; buf_q <= src;
            mem_valid_q <= 1'b1;
            if (mode) begin
              state_q <= ST_WR; mem_addr_q <= dst_al; mem_wdata_q <= src; mem_wstrb_q <= 4'hf;
            end else begin
              state_q <= ST_RD; mem_addr_q <= src_al; mem_wstrb_q <= 4'h0;
            end
          end
        end
        ST_RD: if (mem_ready) begin
          buf_q <= mem_rdata; last_rd_q <= 1'b1; mem_valid_q <= 1'b0; state_q <= ST_GAP;
        end
        ST_WR: if (mem_ready) begin
          src_q <= src_q + 32'd4; dst_q <= dst_q + 32'd4; rem_q <= rem_q - 16'd1;
          last_rd_q <= 1'b0; mem_valid_q <= 1'b0; state_q <= ST_GAP;
        end
        ST_GAP: begin
          // A pending abort lets the word in flight finish its write first.
          if (rem_q == 16'h0 || (abort_pend_q && !last_rd_q)) begin
            state_q <= ST_IDLE; done_q <= 1'b1; abort_pend_q <= 1'b0;
            if (abort_pend_q) st_abort_q <= 1'b1;
            else st_done_q <= 1'b1;
          end else if (last_rd_q || fill_q) begin
            state_q <= ST_WR; mem_valid_q <= 1'b1; mem_addr_q <= dst_q;
            mem_wdata_q <= buf_q; mem_wstrb_q <= 4'hf;
          end else begin
            state_q <= ST_RD; mem_valid_q <= 1'b1; mem_addr_q <= src_q; mem_wstrb_q <= 4'h0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (abort && busy) abort_pend_q <= 1'b1;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_instr = 1'b0;
  assign done      = done_q;

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - directed self-checking bench for bus_dma
module tb_bus_dma;
  import bus_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cs, we;
  logic [7:0]  address;
  logic [31:0] write_data, read_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        ready, mem_valid, mem_instr, done;
  logic        mem_ready = 1'b0;
  logic [3:0]  mem_wstrb;

  int pass_cnt = 0, total_cnt = 0;
  int stall = 0, cnt = 0, rd_n = 0, wr_n = 0, valid_cyc = 0, done_n = 0;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] wr_addr[$], wr_data[$];
  bit ops[$];

  always #5 clk = ~clk;

  bus_dma dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_instr(mem_instr), .done(done)
  );

  always @(posedge clk) begin
    if (done === 1'b1) done_n++;
    if (mem_valid === 1'b1) valid_cyc++;
    #1;
    if (reset) begin
      mem_ready = 1'b0; cnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0; cnt = 0;
    end else if (mem_valid) begin
      if (cnt >= stall) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'h0) begin
          mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
          rd_n++; ops.push_back(1'b0);
        end else begin
          ram[mem_addr] = mem_wdata;
          wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
          wr_n++; ops.push_back(1'b1);
        end
      end else cnt++;
    end
  end

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; address = a;
    @(negedge clk); cs = 1'b0; d = read_data;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    s = 32'h1; n = 0;
    while (s[0] && n < 300) begin reg_read(ADDR_STATUS, s); n++; end
    if (s[0]) begin
      total_cnt++;
      $display("FAIL %s_timeout: busy still %0d, want 0", name, s[0]);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); ops.delete();
  endtask

  task automatic test_reset();
    logic [31:0] s;
    total_cnt++;
    if ({mem_valid, ready, done, mem_instr, mem_wstrb} !== 8'h0) $display("FAIL reset_ctl: got %h want 00", {mem_valid, ready, done, mem_instr, mem_wstrb});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_addr: got %h/%h want 0/0", mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", read_data);
    else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL ready_pulse: got %b want 1", ready);
    else pass_cnt++;
    total_cnt++;
    if (s !== 32'h0) $display("FAIL reset_status: got %h want 0", s);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL ready_drop: got %b want 0", ready);
    else pass_cnt++;
  endtask

  task automatic test_copy();
    logic [31:0] s;
    logic [5:0] seq;
    int d0;
    ram[32'h40000000] = 32'h11111111;
    ram[32'h40000004] = 32'h22222222;
    ram[32'h40000008] = 32'h33333333;
    clear_log(); d0 = done_n;
    reg_write(ADDR_SRC, 32'h40000000); reg_write(ADDR_DST, 32'h40000100);
    reg_write(ADDR_LEN, 32'd3); reg_write(ADDR_MODE, 32'd0);
    reg_write(ADDR_CTRL, 32'h1);
    wait_idle("copy");
    seq = 6'h0;
    for (int i = 0; i < ops.size() && i < 6; i++) seq[5-i] = ops[i];
    total_cnt++;
    if (ops.size() != 6 || seq !== 6'b010101) $display("FAIL copy_order: got %0d ops %b want 6 ops 010101", ops.size(), seq);
    else pass_cnt++;
    total_cnt++;
    if (ram[32'h40000100] !== 32'h11111111 || ram[32'h40000104] !== 32'h22222222 || ram[32'h40000108] !== 32'h33333333)
      $display("FAIL copy_data: got %h %h %h want 11111111 22222222 33333333", ram[32'h40000100], ram[32'h40000104], ram[32'h40000108]);
    else pass_cnt++;
    total_cnt++;
    if (done_n - d0 != 1) $display("FAIL copy_done: got %0d pulses want 1", done_n - d0);
    else pass_cnt++;
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h2) $display("FAIL copy_status: got %h want 2", s);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [31:0] s;
    int r0;
    clear_log(); r0 = rd_n;
    reg_write(ADDR_MODE, 32'd1); reg_write(ADDR_SRC, 32'hDEADBEEF);
    reg_write(ADDR_DST, 32'h40000200); reg_write(ADDR_LEN, 32'd4);
    reg_write(ADDR_CTRL, 32'h1);
    wait_idle("fill");
    total_cnt++;
    if (wr_addr.size() != 4 || rd_n != r0) $display("FAIL fill_count: got %0d writes %0d reads want 4/0", wr_addr.size(), rd_n - r0);
    else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      total_cnt++;
      if (wr_addr[i] !== 32'h40000200 + 32'(4 * i) || wr_data[i] !== 32'hDEADBEEF)
        $display("FAIL fill_word%0d: got %h=%h want %h=deadbeef", i, wr_addr[i], wr_data[i], 32'h40000200 + 32'(4 * i));
      else pass_cnt++;
    end
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h2) $display("FAIL fill_status: got %h want 2", s);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    stall = 5;
    reg_write(ADDR_SRC, 32'h12345678); reg_write(ADDR_DST, 32'h40000300);
    reg_write(ADDR_LEN, 32'd1);
    reg_write(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h40000300, 32'h12345678, 4'hf})
        $display("FAIL hold_cyc%0d: got %b %h %h %h want 1 40000300 12345678 f", i, mem_valid, mem_addr, mem_wdata, mem_wstrb);
      else pass_cnt++;
      @(negedge clk);
    end
    wait_idle("backpressure");
    stall = 0;
  endtask

  task automatic test_abort();
    logic [31:0] s;
    int d0, n;
    clear_log(); d0 = done_n; stall = 3;
    reg_write(ADDR_MODE, 32'd0); reg_write(ADDR_SRC, 32'h40000000);
    reg_write(ADDR_DST, 32'h40000400); reg_write(ADDR_LEN, 32'd8);
    reg_write(ADDR_CTRL, 32'h1);
    n = 0;
    while (!(mem_valid === 1'b1 && mem_wstrb == 4'h0 && mem_addr == 32'h40000004) && n < 200) begin @(negedge clk); n++; end
    total_cnt++;
    if (n >= 200) $display("FAIL abort_wait: second read seen %0d want 1", 0);
    else pass_cnt++;
    reg_write(ADDR_CTRL, 32'h2);
    wait_idle("abort");
    stall = 0;
    total_cnt++;
    if (wr_addr.size() != 2 || ram[32'h40000404] !== 32'h22222222) $display("FAIL abort_writes: got %0d writes, word1 %h want 2, 22222222", wr_addr.size(), ram[32'h40000404]);
    else pass_cnt++;
    total_cnt++;
    if (done_n - d0 != 1) $display("FAIL abort_done: got %0d pulses want 1", done_n - d0);
    else pass_cnt++;
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h4) $display("FAIL abort_status: got %h want 4", s);
    else pass_cnt++;
  endtask

  task automatic test_len0();
    logic [31:0] s;
    int v0;
    reg_write(ADDR_LEN, 32'd0);
    v0 = valid_cyc;
    reg_write(ADDR_CTRL, 32'h1);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL len0_done: got %b want 1", done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL len0_pulse: got %b want 0", done);
    else pass_cnt++;
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h2) $display("FAIL len0_status: got %h want 2", s);
    else pass_cnt++;
    total_cnt++;
    if (valid_cyc != v0) $display("FAIL len0_bus: got %0d valid cycles want 0", valid_cyc - v0);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_log();
    reg_write(ADDR_MODE, 32'd1); reg_write(ADDR_SRC, 32'hA5A5A5A5);
    reg_write(ADDR_DST, 32'hFFFFFFFC); reg_write(ADDR_LEN, 32'd2);
    reg_write(ADDR_CTRL, 32'h1);
    wait_idle("wrap");
    total_cnt++;
    if (wr_addr.size() != 2) $display("FAIL wrap_count: got %0d want 2", wr_addr.size());
    else pass_cnt++;
    if (wr_addr.size() == 2) begin
      total_cnt++;
      if (wr_addr[0] !== 32'hFFFFFFFC || wr_addr[1] !== 32'h0) $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", wr_addr[0], wr_addr[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_abort();
    logic [31:0] s;
    int v0, d0;
    v0 = valid_cyc; d0 = done_n;
    reg_write(ADDR_CTRL, 32'h3);
    repeat (5) @(negedge clk);
    total_cnt++;
    if (valid_cyc != v0 || done_n != d0) $display("FAIL sa_nostart: got %0d valid %0d done want 0 0", valid_cyc - v0, done_n - d0);
    else pass_cnt++;
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h2) $display("FAIL sa_status: got %h want 2", s);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    int d0, n;
    stall = 3;
    reg_write(ADDR_SRC, 32'h55555555); reg_write(ADDR_DST, 32'h40000500);
    reg_write(ADDR_LEN, 32'd4);
    reg_write(ADDR_CTRL, 32'h1);
    n = 0;
    while (mem_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    d0 = done_n;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (mem_valid !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_valid: got %b/%b want 0/0", mem_valid, done);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0; stall = 0;
    repeat (3) @(negedge clk);
    reg_read(ADDR_STATUS, s);
    total_cnt++;
    if (s !== 32'h0) $display("FAIL rst_mid_status: got %h want 0", s);
    else pass_cnt++;
    total_cnt++;
    if (done_n != d0) $display("FAIL rst_mid_done: got %0d pulses want 0", done_n - d0);
    else pass_cnt++;
    reg_read(ADDR_LEN, s);
    total_cnt++;
    if (s !== 32'h0) $display("FAIL rst_mid_len: got %h want 0", s);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_copy();
    test_fill();
    test_backpressure();
    test_abort();
    test_len0();
    test_wrap();
    test_start_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
